// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-entry instruction buffer with req/ack refill and sticky fault reporting
module instr_fetch #(
   parameter int          TIMEOUT   = 255,
   parameter int          CNT_W     = 8,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_addr,
   input  logic        flush,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        stall,
   output logic [1:0]  fault_code,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] FAULT = 2'd2;

   localparam logic [1:0] FC_NONE     = 2'd0;
   localparam logic [1:0] FC_MISALIGN = 2'd1;
   localparam logic [1:0] FC_BUS      = 2'd2;
   localparam logic [1:0] FC_TIMEOUT  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [1:0]       state;
   logic             buf_valid;
   logic [31:0]      buf_addr;
   logic [31:0]      buf_data;
   logic [CNT_W-1:0] cnt;
   logic             discard;
   logic             hit;
   logic             ack_seen;

   assign hit      = buf_valid && (buf_addr == instr_addr);
   assign ack_seen = mem_ack && mem_req;

   // Only IDLE may present a word; FETCH and FAULT always hold the PC.
   always_comb begin
      instr       = NOP_INSTR;
      instr_valid = 1'b0;
      stall       = 1'b1;
      if (state == IDLE && hit) begin
         instr       = buf_data;
         instr_valid = 1'b1;
         stall       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         buf_valid  <= 1'b0;
         buf_addr   <= '0;
         buf_data   <= '0;
         cnt        <= '0;
         discard    <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         fault_code <= FC_NONE;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  buf_valid <= 1'b0;
               end else if (!hit) begin
                  if (instr_addr[1:0] != 2'b00) begin
                     state      <= FAULT;
                     fault_code <= FC_MISALIGN;
                  end else begin
                     state    <= FETCH;
                     mem_req  <= 1'b1;
                     mem_addr <= instr_addr;
                     cnt      <= '0;
                     discard  <= 1'b0;
                  end
               end
            end
            FETCH: begin
               if (ack_seen) begin
                  mem_req <= 1'b0;
                  if (mem_err) begin
                     state      <= FAULT;
                     fault_code <= FC_BUS;
                  end else begin
                     state <= IDLE;
                     // A flush seen at any point of the transaction drops the returned word.
                     if (discard || flush) begin
                        buf_valid <= 1'b0;
                     end else begin
                        buf_valid <= 1'b1;
                        buf_addr  <= mem_addr;
                        buf_data  <= mem_rdata;
                     end
                  end
               end else if (cnt == CNT_LAST) begin
                  mem_req    <= 1'b0;
                  state      <= FAULT;
                  fault_code <= FC_TIMEOUT;
               end else begin
                  if (cnt != CNT_MAX) begin
                     cnt <= cnt + 1'b1;
                  end
                  if (flush) begin
                     discard <= 1'b1;
                  end
               end
            end
            FAULT: begin
               if (flush) begin
                  state      <= IDLE;
                  fault_code <= FC_NONE;
                  buf_valid  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - cycle-table and scoreboard bench for instr_fetch
module tb_instr_fetch;

   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct {
      logic [31:0] addr;
      logic        flush;
      logic        ack;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] e_instr;
      logic        e_valid;
      logic        e_stall;
      logic        e_req;
      logic [31:0] e_maddr;
      logic [1:0]  e_fault;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_addr;
   logic        flush;
   logic [31:0] instr;
   logic        instr_valid;
   logic        stall;
   logic [1:0]  fault_code;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_err;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t exp_q[$];
   vec_t tbl[$];

   instr_fetch #(.TIMEOUT(4), .CNT_W(8), .NOP_INSTR(NOP)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_addr  (instr_addr),
      .flush       (flush),
      .instr       (instr),
      .instr_valid (instr_valid),
      .stall       (stall),
      .fault_code  (fault_code),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .mem_err     (mem_err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [31:0] a, input logic f, input logic k, input logic e,
                               input logic [31:0] rd, input logic [31:0] ei, input logic ev,
                               input logic es, input logic er, input logic [31:0] em,
                               input logic [1:0] ef);
      vec_t v;
      v.addr = a; v.flush = f; v.ack = k; v.err = e; v.rdata = rd;
      v.e_instr = ei; v.e_valid = ev; v.e_stall = es; v.e_req = er;
      v.e_maddr = em; v.e_fault = ef;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called on a negedge: drive, sample 2ns later, leave on the next negedge.
   task automatic step(input vec_t v, input string tag);
      vec_t e;
      instr_addr = v.addr;
      flush      = v.flush;
      mem_ack    = v.ack;
      mem_err    = v.err;
      mem_rdata  = v.rdata;
      exp_q.push_back(v);
      #2;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, ".instr"},       instr,              e.e_instr);
         chk({tag, ".instr_valid"}, 32'(instr_valid),   32'(e.e_valid));
         chk({tag, ".stall"},       32'(stall),         32'(e.e_stall));
         chk({tag, ".mem_req"},     32'(mem_req),       32'(e.e_req));
         chk({tag, ".mem_addr"},    mem_addr,           e.e_maddr);
         chk({tag, ".fault_code"},  32'(fault_code),    32'(e.e_fault));
      end
      @(negedge clk);
   endtask

   initial begin
      reset      = 1'b0;
      instr_addr = '0;
      flush      = 1'b0;
      mem_ack    = 1'b0;
      mem_err    = 1'b0;
      mem_rdata  = '0;

      // miss at 0x0, ack on first sampled edge
      tbl.push_back(mk(32'h00, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h00, 0));
      tbl.push_back(mk(32'h00, 0, 1, 0, 32'h00500093, NOP, 0, 1, 1, 32'h00, 0));
      tbl.push_back(mk(32'h00, 0, 0, 0, 0, 32'h00500093, 1, 0, 0, 32'h00, 0));
      // sequential miss at 0x4 with three wait cycles
      tbl.push_back(mk(32'h04, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h00, 0));
      tbl.push_back(mk(32'h04, 0, 0, 0, 0,            NOP, 0, 1, 1, 32'h04, 0));
      tbl.push_back(mk(32'h04, 0, 0, 0, 0,            NOP, 0, 1, 1, 32'h04, 0));
      tbl.push_back(mk(32'h04, 0, 0, 0, 0,            NOP, 0, 1, 1, 32'h04, 0));
      tbl.push_back(mk(32'h04, 0, 1, 0, 32'h00A00113, NOP, 0, 1, 1, 32'h04, 0));
      tbl.push_back(mk(32'h04, 0, 0, 0, 0, 32'h00A00113, 1, 0, 0, 32'h04, 0));
      tbl.push_back(mk(32'h04, 0, 0, 0, 0, 32'h00A00113, 1, 0, 0, 32'h04, 0));
      // misaligned fault, sticky, cleared by flush, repeats, then 0x8 fetches
      tbl.push_back(mk(32'h06, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h04, 0));
      tbl.push_back(mk(32'h06, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h04, 1));
      tbl.push_back(mk(32'h04, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h04, 1));
      tbl.push_back(mk(32'h06, 1, 0, 0, 0,            NOP, 0, 1, 0, 32'h04, 1));
      tbl.push_back(mk(32'h06, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h04, 0));
      tbl.push_back(mk(32'h06, 1, 0, 0, 0,            NOP, 0, 1, 0, 32'h04, 1));
      tbl.push_back(mk(32'h08, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h04, 0));
      tbl.push_back(mk(32'h08, 0, 1, 0, 32'h00000293, NOP, 0, 1, 1, 32'h08, 0));
      tbl.push_back(mk(32'h08, 0, 0, 0, 0, 32'h00000293, 1, 0, 0, 32'h08, 0));
      // flush mid-fetch discards the first word, refetch delivers the second
      tbl.push_back(mk(32'h20, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h08, 0));
      tbl.push_back(mk(32'h20, 1, 0, 0, 0,            NOP, 0, 1, 1, 32'h20, 0));
      tbl.push_back(mk(32'h20, 0, 1, 0, 32'hDEADBEEF, NOP, 0, 1, 1, 32'h20, 0));
      tbl.push_back(mk(32'h20, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h20, 0));
      tbl.push_back(mk(32'h20, 0, 1, 0, 32'h00100073, NOP, 0, 1, 1, 32'h20, 0));
      tbl.push_back(mk(32'h20, 0, 0, 0, 0, 32'h00100073, 1, 0, 0, 32'h20, 0));
      // redirect during fetch: fill at latched address, then refetch
      tbl.push_back(mk(32'h24, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h20, 0));
      tbl.push_back(mk(32'h28, 0, 0, 0, 0,            NOP, 0, 1, 1, 32'h24, 0));
      tbl.push_back(mk(32'h28, 0, 1, 0, 32'h11111111, NOP, 0, 1, 1, 32'h24, 0));
      tbl.push_back(mk(32'h28, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h24, 0));
      tbl.push_back(mk(32'h28, 0, 1, 0, 32'h22222222, NOP, 0, 1, 1, 32'h28, 0));
      tbl.push_back(mk(32'h28, 0, 0, 0, 0, 32'h22222222, 1, 0, 0, 32'h28, 0));

      repeat (2) @(negedge clk);
      #2;
      chk("rst.instr",       instr,            NOP);
      chk("rst.instr_valid", 32'(instr_valid), 32'd0);
      chk("rst.stall",       32'(stall),       32'd1);
      chk("rst.mem_req",     32'(mem_req),     32'd0);
      chk("rst.mem_addr",    mem_addr,         32'd0);
      chk("rst.fault_code",  32'(fault_code),  32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end

      // bus error keeps the buffered word
      step(mk(32'h10, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h28, 0), "buserr0");
      step(mk(32'h10, 0, 1, 1, 32'hBADBAD00, NOP, 0, 1, 1, 32'h10, 0), "buserr1");
      step(mk(32'h10, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h10, 2), "buserr2");
      chk("buserr.buf_data", dut.buf_data, 32'h22222222);
      chk("buserr.buf_addr", dut.buf_addr, 32'h28);
      step(mk(32'h28, 1, 0, 0, 0,            NOP, 0, 1, 0, 32'h10, 2), "buserr3");

      // timeout after 4 cycles, late ack ignored
      step(mk(32'h30, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h10, 0), "tmo0");
      for (int i = 1; i <= 4; i++) begin
         step(mk(32'h30, 0, 0, 0, 0,         NOP, 0, 1, 1, 32'h30, 0), $sformatf("tmo%0d", i));
      end
      step(mk(32'h30, 0, 1, 0, 32'h33333333, NOP, 0, 1, 0, 32'h30, 3), "tmo5");
      step(mk(32'h30, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h30, 3), "tmo6");
      step(mk(32'h30, 1, 0, 0, 0,            NOP, 0, 1, 0, 32'h30, 3), "tmo7");

      // stray ack in IDLE does not complete anything
      step(mk(32'h30, 0, 1, 0, 32'h44444444, NOP, 0, 1, 0, 32'h30, 0), "stray0");
      step(mk(32'h30, 0, 0, 0, 0,            NOP, 0, 1, 1, 32'h30, 0), "stray1");

      // asynchronous reset while the request is outstanding
      #2;
      reset = 1'b0;
      #1;
      chk("arst.mem_req",     32'(mem_req),     32'd0);
      chk("arst.instr_valid", 32'(instr_valid), 32'd0);
      chk("arst.fault_code",  32'(fault_code),  32'd0);
      chk("arst.mem_addr",    mem_addr,         32'd0);
      chk("arst.instr",       instr,            NOP);
      @(negedge clk);
      reset = 1'b1;
      step(mk(32'h28, 0, 0, 0, 0,            NOP, 0, 1, 0, 32'h00, 0), "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
